// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - hazard/stall controller with MDU busy sequencer for a five-stage pipeline
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   D_rs, D_rt            source register addresses of the instruction in D
//   D_tuse_rs, D_tuse_rt  cycles until D needs each source (3 = not used)
//   D_md                  D instruction uses HI/LO/MDU
//   E_wa, E_tnew          destination and result latency of the E instruction
//   M_wa, M_tnew          destination and result latency of the M instruction
//   E_md_start, E_md_div  mult/div issuing from E this cycle; 1 = divide
//   PCWE, D_en            fetch PC write enable, IF/ID enable (low on stall)
//   E_flush               ID/EX bubble insert (high on stall)
//   md_busy               MDU sequencer counting
//   stall_cnt             stall cycles since reset, wraps at 2^32

module pipe_stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic        D_md,
    input  logic [4:0]  E_wa,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_wa,
    input  logic [1:0]  M_tnew,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        PCWE,
    output logic        D_en,
    output logic        E_flush,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [3:0] md_cnt;
    logic       hit_rs_e;
    logic       hit_rs_m;
    logic       hit_rt_e;
    logic       hit_rt_m;
    logic       reg_stall;
    logic       md_stall;
    logic       stall;

    // A source stalls only when its producer cannot deliver in time to be
    // forwarded; $0 is hard-wired so it never creates a dependency.
    always_comb begin
        hit_rs_e  = (D_rs != 5'd0) && (D_rs == E_wa) && (D_tuse_rs < E_tnew);
        hit_rs_m  = (D_rs != 5'd0) && (D_rs == M_wa) && (D_tuse_rs < M_tnew);
        hit_rt_e  = (D_rt != 5'd0) && (D_rt == E_wa) && (D_tuse_rt < E_tnew);
        hit_rt_m  = (D_rt != 5'd0) && (D_rt == M_wa) && (D_tuse_rt < M_tnew);
        reg_stall = hit_rs_e | hit_rs_m | hit_rt_e | hit_rt_m;
        // E_md_start covers the issue cycle, before md_cnt has been loaded.
        md_stall  = D_md & (E_md_start | md_busy);
        stall     = reg_stall | md_stall;
        PCWE      = ~stall;
        D_en      = ~stall;
        E_flush   = stall;
    end

    assign md_busy = (md_cnt != 4'd0);

    // A start while already busy is ignored: the running count continues.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= 4'd0;
        end else if (E_md_start && !md_busy) begin
            md_cnt <= E_md_div ? DIV_LOAD : MULT_LOAD;
        end else if (md_busy) begin
            md_cnt <= md_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - scoreboard bench for pipe_stall_ctrl with directed vectors

module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  D_rs = '0;
    logic [4:0]  D_rt = '0;
    logic [1:0]  D_tuse_rs = 2'd3;
    logic [1:0]  D_tuse_rt = 2'd3;
    logic        D_md = 1'b0;
    logic [4:0]  E_wa = '0;
    logic [1:0]  E_tnew = '0;
    logic [4:0]  M_wa = '0;
    logic [1:0]  M_tnew = '0;
    logic        E_md_start = 1'b0;
    logic        E_md_div = 1'b0;
    logic        PCWE;
    logic        D_en;
    logic        E_flush;
    logic        md_busy;
    logic [31:0] stall_cnt;

    pipe_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
        .D_md(D_md), .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
        .E_md_start(E_md_start), .E_md_div(E_md_div),
        .PCWE(PCWE), .D_en(D_en), .E_flush(E_flush),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        stall;
        logic        busy;
        logic [31:0] cnt;
        logic        chk_state;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   vec_no = 0;

    task automatic chk1(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0h required %0h", name, idx, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents a result.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk1("PCWE",    e.idx, {31'd0, PCWE},    {31'd0, ~e.stall});
            chk1("D_en",    e.idx, {31'd0, D_en},    {31'd0, ~e.stall});
            chk1("E_flush", e.idx, {31'd0, E_flush}, {31'd0, e.stall});
            if (e.chk_state) begin
                chk1("md_busy",   e.idx, {31'd0, md_busy}, {31'd0, e.busy});
                chk1("stall_cnt", e.idx, stall_cnt, e.cnt);
            end
        end
    end

    // One cycle of stimulus plus the hand-computed response for that cycle.
    task automatic v(
        input logic rst,
        input logic [4:0] rs, input logic [1:0] trs,
        input logic [4:0] rt, input logic [1:0] trt,
        input logic md,
        input logic [4:0] ewa, input logic [1:0] etn,
        input logic [4:0] mwa, input logic [1:0] mtn,
        input logic st, input logic dv,
        input logic x_stall, input logic x_busy, input logic [31:0] x_cnt,
        input logic chk_state
    );
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; D_rs = rs; D_tuse_rs = trs; D_rt = rt; D_tuse_rt = trt;
        D_md = md; E_wa = ewa; E_tnew = etn; M_wa = mwa; M_tnew = mtn;
        E_md_start = st; E_md_div = dv;
        e.idx = vec_no; e.stall = x_stall; e.busy = x_busy; e.cnt = x_cnt; e.chk_state = chk_state;
        exp_q.push_back(e);
        vec_no++;
    endtask

    initial begin
        //  rst rs trs rt trt md ewa etn mwa mtn st dv | stall busy cnt chk
        v(1, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);   // reset, idle inputs
        v(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);   // reset state
        // load-use: E producer, then the same producer in M
        v(0, 8, 0, 0, 3, 0, 8, 2, 0, 0, 0, 0,  1, 0, 0, 1);
        v(0, 8, 0, 0, 3, 0, 0, 0, 8, 1, 0, 0,  1, 0, 1, 1);
        v(0, 8, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 1);
        // $0 never stalls
        v(0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0,  0, 0, 2, 1);
        // forwardable rt, then rt hazards from E and from M, then unused source
        v(0, 0, 3, 9, 1, 0, 9, 1, 0, 0, 0, 0,  0, 0, 2, 1);
        v(0, 0, 3, 9, 1, 0, 9, 2, 0, 0, 0, 0,  1, 0, 2, 1);
        v(0, 0, 3, 9, 0, 0, 0, 0, 9, 1, 0, 0,  1, 0, 3, 1);
        v(0, 9, 3, 0, 3, 0, 9, 2, 0, 0, 0, 0,  0, 0, 4, 1);
        // divide with dependent mflo held in D: 11 stall cycles
        v(0, 0, 3, 0, 3, 1, 0, 0, 0, 0, 1, 1,  1, 0, 4, 1);
        for (int i = 1; i <= 10; i++)
            v(0, 0, 3, 0, 3, 1, 0, 0, 0, 0, 0, 0,  1, 1, 32'(4 + i), 1);
        v(0, 0, 3, 0, 3, 1, 0, 0, 0, 0, 0, 0,  0, 0, 15, 1);
        // multiply, nothing dependent: 5 busy cycles, no stall
        v(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 1, 0,  0, 0, 15, 1);
        for (int i = 1; i <= 5; i++)
            v(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0,  0, 1, 15, 1);
        v(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0,  0, 0, 15, 1);
        // simultaneous reg and md stall counted once; illegal restart ignored
        v(0, 8, 0, 0, 3, 1, 8, 2, 0, 0, 1, 0,  1, 0, 15, 1);
        v(0, 0, 3, 0, 3, 1, 0, 0, 0, 0, 0, 0,  1, 1, 16, 1);
        v(0, 0, 3, 0, 3, 1, 0, 0, 0, 0, 1, 1,  1, 1, 17, 1);
        for (int i = 0; i < 3; i++)
            v(0, 0, 3, 0, 3, 1, 0, 0, 0, 0, 0, 0,  1, 1, 32'(18 + i), 1);
        v(0, 0, 3, 0, 3, 1, 0, 0, 0, 0, 0, 0,  0, 0, 21, 1);
        // reset during a divide
        v(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 1, 1,  0, 0, 21, 1);
        v(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0,  0, 1, 21, 1);
        v(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0,  0, 1, 21, 1);
        v(1, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0,  0, 1, 21, 1);
        v(0, 0, 3, 0, 3, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        v(0, 0, 3, 0, 3, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Hazard and stall controller for the five-stage MIPS pipeline. Compares source-register demand in D (Tuse) against pending results in E and M (Tnew) and decides whether the front end freezes. It owns the multiply/divide busy sequencer, drives the fetch unit's PC write enable, the IF/ID enable and the ID/EX flush, and keeps a stall-cycle counter for performance checks.

## Interface
- MULT_CYCLES, 5, busy cycles after a mult/multu issues from E
- DIV_CYCLES, 10, busy cycles after a div/divu issues from E
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- D_rs  input  5  rs address of instruction in D
- D_rt  input  5  rt address of instruction in D
- D_tuse_rs  input  2  cycles until D needs rs (3 = not used)
- D_tuse_rt  input  2  cycles until D needs rt (3 = not used)
- D_md  input  1  D instruction touches HI/LO/MDU (mult, div, mfhi, mflo, mthi, mtlo)
- E_wa  input  5  destination register of E instruction (0 = none)
- E_tnew  input  2  cycles until E result is available
- M_wa  input  5  destination register of M instruction (0 = none)
- M_tnew  input  2  cycles until M result is available
- E_md_start  input  1  E holds mult/multu/div/divu this cycle
- E_md_div  input  1  qualifies E_md_start: 1 = divide, 0 = multiply
- PCWE  output  1  fetch PC write enable
- D_en  output  1  IF/ID register enable
- E_flush  output  1  ID/EX clear (bubble insert)
- md_busy  output  1  MDU sequencer counting
- stall_cnt  output  32  total stall cycles since reset

## Operation
- Register hazard, per source s in {rs, rt} and stage X in {E, M}: hit = (D_s != 0) & (D_s == X_wa) & (D_tuse_s < X_tnew).
- reg_stall = OR of the four hits.
- md_stall = D_md & (E_md_start | md_busy).
- stall = reg_stall | md_stall.
- PCWE = D_en = ~stall. E_flush = stall.
- Sequencer: 4-bit down counter md_cnt. md_busy = (md_cnt != 0).
  - If E_md_start & ~md_busy: load DIV_CYCLES when E_md_div = 1, else MULT_CYCLES.
  - Else if md_busy: decrement.
  - Else: hold 0.
- E_md_start while md_busy is a protocol violation. It is ignored: no reload, and the count continues. The stall logic makes it unreachable.
- stall_cnt increments by 1 in every non-reset cycle with stall = 1. It wraps from 0xFFFFFFFF to 0.
- Tnew values arrive already aged by the stage registers. This block holds no pipeline copy of them.

## Timing
- Reset values, effective the cycle after reset is sampled high: md_cnt = 0, md_busy = 0, stall_cnt = 0.
- With inputs idle during reset, the outputs are PCWE = 1, D_en = 1, E_flush = 0.
- Reset mid-operation aborts any MDU count immediately.
- stall, PCWE, D_en and E_flush are combinational from the inputs and md_cnt, with zero-cycle latency. They are valid before the same rising edge they gate.
- Start at edge t: md_busy is high from t+1 through t+N inclusive (N = MULT_CYCLES or DIV_CYCLES) and low at t+N+1.
- In the start cycle itself, md_stall is still driven by E_md_start.
- A D instruction with D_md stalls while md_busy is high. It proceeds in the first cycle with md_busy = 0 and no E_md_start.
- Simultaneous reg_stall and md_stall produce one stall cycle, counted once.
- The $0 destination never stalls, even if E_tnew > 0.

## Test plan
- Load-use: E_wa = 8, E_tnew = 2, D_rs = 8, D_tuse_rs = 0 -> PCWE = 0, D_en = 0, E_flush = 1 for 1 cycle, stall_cnt = 1. Next cycle the pipeline drives M_wa = 8, M_tnew = 1 -> stall continues 1 more cycle, then PCWE = 1.
- Zero register: E_wa = 0, E_tnew = 2, D_rs = 0, D_tuse_rs = 0 -> no stall, stall_cnt unchanged.
- Forwardable: E_wa = 9, E_tnew = 1, D_rt = 9, D_tuse_rt = 1 -> no stall.
- Divide then mflo: E_md_start = 1, E_md_div = 1 at edge t, with D_md = 1 held -> stall in cycles t through t+10 (11 cycles), PCWE = 1 at t+11, stall_cnt = 11.
- Mult with no dependent instruction: E_md_start = 1, E_md_div = 0, D_md = 0 -> md_busy high for exactly 5 cycles, no stalls.
- Reset during a divide: assert reset at cycle t+3 -> md_busy = 0 and stall_cnt = 0 at t+4, and D_md = 1 no longer stalls.
